// File: rtl/ycbcr2rgb.sv
// Four-stage full-range BT.601 YCbCr 4:4:4 to RGB converter with a per-frame clipped-pixel counter.
// Define YCBCR2RGB_ROUND_EN to round half up before the final shift; otherwise the result is truncated.
module ycbcr2rgb #(
    parameter int P_DATA_DEPTH     = 8,
    parameter int P_R_Cr_factor    = 1436,
    parameter int P_G_Cb_factor    = 352,
    parameter int P_G_Cr_factor    = 731,
    parameter int P_B_Cb_factor    = 1815,
    parameter int P_CHROMA_OFFSET  = 128,
    parameter int P_CLIP_CNT_WIDTH = 22
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [P_DATA_DEPTH-1:0]     i_Y_channel,
    input  logic [P_DATA_DEPTH-1:0]     i_Cb_channel,
    input  logic [P_DATA_DEPTH-1:0]     i_Cr_channel,
    input  logic                        i_img_hsync,
    input  logic                        i_img_vsync,
    output logic [P_DATA_DEPTH-1:0]     o_red_channel,
    output logic [P_DATA_DEPTH-1:0]     o_green_channel,
    output logic [P_DATA_DEPTH-1:0]     o_blue_channel,
    output logic                        o_img_hsync,
    output logic                        o_img_vsync,
    output logic [P_CLIP_CNT_WIDTH-1:0] o_clip_cnt
);

    localparam logic signed [11:0] K_R_CR = 12'(P_R_Cr_factor);
    localparam logic signed [11:0] K_G_CB = 12'(P_G_Cb_factor);
    localparam logic signed [11:0] K_G_CR = 12'(P_G_Cr_factor);
    localparam logic signed [11:0] K_B_CB = 12'(P_B_Cb_factor);
    localparam logic signed [8:0]  K_OFS  = 9'(P_CHROMA_OFFSET);
`ifdef YCBCR2RGB_ROUND_EN
    localparam logic signed [20:0] K_RND  = 21'sd512;
`else
    localparam logic signed [20:0] K_RND  = 21'sd0;
`endif

    logic [3:0]               valid_q, vsync_q;
    logic [7:0]               y1_q;
    logic signed [8:0]        cb1_q, cr1_q, cb1_d, cr1_d;
    logic signed [20:0]       y2_q, rcr_q, gcb_q, gcr_q, bcb_q;
    logic signed [20:0]       rcr_d, gcb_d, gcr_d, bcb_d;
    logic signed [20:0]       sR_q, sG_q, sB_q, sR_d, sG_d, sB_d;
    logic [7:0]               red_q, green_q, blue_q, red_d, green_d, blue_d;
    logic [P_CLIP_CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                     clipR, clipG, clipB, pixClip, vsRise;

    // Shift right by 10 and saturate to 0..255; bit 8 of the result flags a clamp.
    function automatic logic [8:0] clampChannel(input logic signed [20:0] sum);
        logic signed [20:0] s;
        s = sum >>> 10;
        if (s < 0)
            clampChannel = {1'b1, 8'd0};
        else if (s > 255)
            clampChannel = {1'b1, 8'd255};
        else
            clampChannel = {1'b0, s[7:0]};
    endfunction

    always_comb begin
        cb1_d = $signed({1'b0, i_Cb_channel}) - K_OFS;
        cr1_d = $signed({1'b0, i_Cr_channel}) - K_OFS;

        rcr_d = '0;
        gcb_d = '0;
        gcr_d = '0;
        bcb_d = '0;
        if (valid_q[0]) begin
            rcr_d = K_R_CR * cr1_q;
            gcb_d = K_G_CB * cb1_q;
            gcr_d = K_G_CR * cr1_q;
            bcb_d = K_B_CB * cb1_q;
        end

        sR_d = y2_q + rcr_q + K_RND;
        sG_d = y2_q - gcb_q - gcr_q + K_RND;
        sB_d = y2_q + bcb_q + K_RND;

        {clipR, red_d}   = clampChannel(sR_q);
        {clipG, green_d} = clampChannel(sG_q);
        {clipB, blue_d}  = clampChannel(sB_q);
        if (!valid_q[2]) begin
            red_d   = '0;
            green_d = '0;
            blue_d  = '0;
        end

        // The counter is updated on the same edge that presents the pixel at the outputs.
        pixClip = valid_q[2] & (clipR | clipG | clipB);
        vsRise  = vsync_q[2] & ~vsync_q[3];
        cnt_d   = cnt_q;
        if (vsRise)
            cnt_d = {{(P_CLIP_CNT_WIDTH-1){1'b0}}, pixClip};
        else if (pixClip && (cnt_q != '1))
            cnt_d = cnt_q + P_CLIP_CNT_WIDTH'(1);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q <= '0;
            vsync_q <= '0;
            y1_q    <= '0;
            cb1_q   <= '0;
            cr1_q   <= '0;
            y2_q    <= '0;
            rcr_q   <= '0;
            gcb_q   <= '0;
            gcr_q   <= '0;
            bcb_q   <= '0;
            sR_q    <= '0;
            sG_q    <= '0;
            sB_q    <= '0;
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= {valid_q[2:0], i_img_hsync & i_img_vsync};
            vsync_q <= {vsync_q[2:0], i_img_vsync};
            y1_q    <= i_Y_channel;
            cb1_q   <= cb1_d;
            cr1_q   <= cr1_d;
            y2_q    <= $signed({3'b000, y1_q, 10'b0});
            rcr_q   <= rcr_d;
            gcb_q   <= gcb_d;
            gcr_q   <= gcr_d;
            bcb_q   <= bcb_d;
            sR_q    <= sR_d;
            sG_q    <= sG_d;
            sB_q    <= sB_d;
            red_q   <= red_d;
            green_q <= green_d;
            blue_q  <= blue_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_red_channel   = red_q;
    assign o_green_channel = green_q;
    assign o_blue_channel  = blue_q;
    assign o_img_hsync     = valid_q[3];
    assign o_img_vsync     = vsync_q[3];
    assign o_clip_cnt      = cnt_q;

endmodule

// File: tb/tb_ycbcr2rgb.sv
// Directed bench for ycbcr2rgb: table of hand-computed pixels plus frame, reset and saturation sequences.
// A second instance with a 4-bit counter exercises counter saturation in a short run.
module tb_ycbcr2rgb;

    typedef struct {
        logic [7:0] y, cb, cr;
        logic       hs, vs;
        logic [7:0] r, g, b;
        logic       clip;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  yIn = '0, cbIn = '0, crIn = '0;
    logic        hsIn = 1'b0, vsIn = 1'b0;
    logic [7:0]  red, green, blue, redS, greenS, blueS;
    logic        hsOut, vsOut, hsOutS, vsOutS;
    logic [21:0] clipCnt;
    logic [3:0]  clipCntS;

    int totalChecks = 0;
    int passChecks  = 0;
    vec_t vecs[12];

    ycbcr2rgb dut (
        .i_clk(clock), .i_rst(reset),
        .i_Y_channel(yIn), .i_Cb_channel(cbIn), .i_Cr_channel(crIn),
        .i_img_hsync(hsIn), .i_img_vsync(vsIn),
        .o_red_channel(red), .o_green_channel(green), .o_blue_channel(blue),
        .o_img_hsync(hsOut), .o_img_vsync(vsOut), .o_clip_cnt(clipCnt)
    );

    ycbcr2rgb #(.P_CLIP_CNT_WIDTH(4)) dutSmall (
        .i_clk(clock), .i_rst(reset),
        .i_Y_channel(yIn), .i_Cb_channel(cbIn), .i_Cr_channel(crIn),
        .i_img_hsync(hsIn), .i_img_vsync(vsIn),
        .o_red_channel(redS), .o_green_channel(greenS), .o_blue_channel(blueS),
        .o_img_hsync(hsOutS), .o_img_vsync(vsOutS), .o_clip_cnt(clipCntS)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] y, input logic [7:0] cb, input logic [7:0] cr,
                                 input logic hs, input logic vs);
        yIn  = y;
        cbIn = cb;
        crIn = cr;
        hsIn = hs;
        vsIn = vs;
    endtask

    task automatic checkField(input string name, input int actual, input int expected);
        totalChecks++;
        if (actual == expected)
            passChecks++;
        else
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic checkOutput(input string tag, input int r, input int g, input int b,
                               input int hs, input int vs);
        checkField({tag, " red"},   int'(red),   r);
        checkField({tag, " green"}, int'(green), g);
        checkField({tag, " blue"},  int'(blue),  b);
        checkField({tag, " hsync"}, int'(hsOut), hs);
        checkField({tag, " vsync"}, int'(vsOut), vs);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(8'd0, 8'd128, 8'd128, 1'b0, 1'b0);
            tick();
        end
    endtask

    initial begin
        int  expCnt;
        bit  prevVs;
        bit  isClip;

        vecs[0]  = '{8'd128, 8'd128, 8'd128, 1'b1, 1'b1, 8'd128, 8'd128, 8'd128, 1'b0};
        vecs[1]  = '{8'd255, 8'd128, 8'd255, 1'b1, 1'b1, 8'd255, 8'd164, 8'd255, 1'b1};
        vecs[2]  = '{8'd0,   8'd0,   8'd0,   1'b1, 1'b1, 8'd0,   8'd135, 8'd0,   1'b1};
        vecs[3]  = '{8'd76,  8'd85,  8'd255, 1'b1, 1'b1, 8'd254, 8'd0,   8'd0,   1'b1};
        vecs[4]  = '{8'd0,   8'd0,   8'd0,   1'b0, 1'b1, 8'd0,   8'd0,   8'd0,   1'b1};
        vecs[5]  = '{8'd100, 8'd128, 8'd128, 1'b1, 1'b1, 8'd100, 8'd100, 8'd100, 1'b0};
        vecs[6]  = '{8'd255, 8'd128, 8'd128, 1'b1, 1'b1, 8'd255, 8'd255, 8'd255, 1'b0};
        vecs[7]  = '{8'd0,   8'd128, 8'd128, 1'b1, 1'b1, 8'd0,   8'd0,   8'd0,   1'b0};
        vecs[8]  = '{8'd128, 8'd255, 8'd128, 1'b1, 1'b1, 8'd128, 8'd84,  8'd255, 1'b1};
        vecs[9]  = '{8'd128, 8'd128, 8'd0,   1'b1, 1'b1, 8'd0,   8'd219, 8'd128, 1'b1};
        vecs[10] = '{8'd50,  8'd128, 8'd128, 1'b1, 1'b1, 8'd50,  8'd50,  8'd50,  1'b0};
        vecs[11] = '{8'd200, 8'd128, 8'd128, 1'b1, 1'b1, 8'd200, 8'd200, 8'd200, 1'b0};

        reset = 1'b1;
        applyStimulus(8'd0, 8'd128, 8'd128, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("reset", 0, 0, 0, 0, 0);
        checkField("reset clipCnt", int'(clipCnt), 0);
        reset = 1'b0;

        // Back-to-back stream; each pixel appears 4 edges after it is sampled.
        expCnt = 0;
        prevVs = 1'b0;
        for (int c = 0; c < 15; c++) begin
            if (c < 12)
                applyStimulus(vecs[c].y, vecs[c].cb, vecs[c].cr, vecs[c].hs, vecs[c].vs);
            else
                applyStimulus(8'd0, 8'd128, 8'd128, 1'b0, 1'b0);
            tick();
            if (c >= 3) begin
                int  k;
                bit  ov, oh;
                k  = c - 3;
                ov = vecs[k].vs;
                oh = vecs[k].hs & vecs[k].vs;
                checkOutput($sformatf("vec%0d", k), vecs[k].r, vecs[k].g, vecs[k].b, oh, ov);
                if (ov && !prevVs)
                    expCnt = (oh && vecs[k].clip) ? 1 : 0;
                else if (oh && vecs[k].clip)
                    expCnt++;
                prevVs = ov;
                checkField($sformatf("vec%0d clipCnt", k), int'(clipCnt), expCnt);
            end
        end

        idle(6);
        checkField("vblank hold clipCnt", int'(clipCnt), 5);
        checkField("vblank vsync", int'(vsOut), 0);

        for (int p = 0; p < 10; p++) begin
            isClip = (p == 2) || (p == 5) || (p == 7);
            applyStimulus(isClip ? 8'd0 : 8'd100, isClip ? 8'd0 : 8'd128,
                          isClip ? 8'd0 : 8'd128, 1'b1, 1'b1);
            tick();
        end
        idle(8);
        checkOutput("frameA vblank", 0, 0, 0, 0, 0);
        checkField("frameA clipCnt", int'(clipCnt), 3);

        // New frame whose first pixel clips on the vsync-rise cycle.
        applyStimulus(8'd0, 8'd0, 8'd0, 1'b1, 1'b1);
        tick();
        applyStimulus(8'd100, 8'd128, 8'd128, 1'b1, 1'b1);
        tick();
        applyStimulus(8'd0, 8'd128, 8'd128, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("frameB first", 0, 135, 0, 1, 1);
        checkField("frameB rise clipCnt", int'(clipCnt), 1);
        idle(6);
        checkField("frameB hold clipCnt", int'(clipCnt), 1);

        applyStimulus(8'd100, 8'd128, 8'd128, 1'b1, 1'b1);
        tick();
        idle(3);
        checkOutput("frameC first", 100, 100, 100, 1, 1);
        checkField("frameC rise clipCnt", int'(clipCnt), 0);
        idle(6);

        // Reset with three pixels in flight.
        for (int p = 0; p < 3; p++) begin
            applyStimulus(8'd0, 8'd0, 8'd0, 1'b1, 1'b1);
            tick();
        end
        reset = 1'b1;
        applyStimulus(8'd0, 8'd128, 8'd128, 1'b0, 1'b0);
        tick();
        checkOutput("midReset", 0, 0, 0, 0, 0);
        checkField("midReset clipCnt", int'(clipCnt), 0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput($sformatf("postReset%0d", i), 0, 0, 0, 0, 0);
        end
        checkField("postReset clipCnt", int'(clipCnt), 0);

        for (int p = 0; p < 20; p++) begin
            applyStimulus(8'd0, 8'd0, 8'd0, 1'b1, 1'b1);
            tick();
        end
        idle(6);
        checkField("sat wide clipCnt", int'(clipCnt), 20);
        checkField("sat narrow clipCnt", int'(clipCntS), 15);

        $display("%0d/%0d checks passed", passChecks, totalChecks);
        $finish;
    end

endmodule

// File: doc/ycbcr2rgb.md
Name: ycbcr2rgb

Overview:
- Converts the YCbCr 4:4:4 stream from the RGB-to-YCbCr stage back to 8-bit RGB, using full-range BT.601 integer coefficients scaled by 1024.
- Sits on the VGA/HDMI-timed video path after YCbCr-domain processing, feeding display output or further RGB stages.
- Fixed-latency pipeline: timing strobes are delayed to match the data.
- Counts clipped pixels per frame for debug.

Parameters:
- P_DATA_DEPTH, 8: width of each input and output channel; only 8 is supported.
- P_R_Cr_factor, 1436: 1.402 x 1024.
- P_G_Cb_factor, 352: 0.344136 x 1024.
- P_G_Cr_factor, 731: 0.714136 x 1024.
- P_B_Cb_factor, 1815: 1.772 x 1024.
- P_CHROMA_OFFSET, 128: chroma zero level.
- P_CLIP_CNT_WIDTH, 22: width of the per-frame clip counter.

Ports:
- i_clk  in  1  pixel clock.
- i_rst  in  1  reset. One clock; reset is synchronous and active-high.
- i_Y_channel  in  8  luma.
- i_Cb_channel  in  8  blue-difference chroma.
- i_Cr_channel  in  8  red-difference chroma.
- i_img_hsync  in  1  line-active strobe.
- i_img_vsync  in  1  frame-active strobe.
- o_red_channel  out  8  R.
- o_green_channel  out  8  G.
- o_blue_channel  out  8  B.
- o_img_hsync  out  1  pixel valid: hsync AND vsync, delayed.
- o_img_vsync  out  1  vsync, delayed.
- o_clip_cnt  out  P_CLIP_CNT_WIDTH  clipped-pixel count for the current frame.

Behaviour:
- Reset: all pipeline registers, outputs and o_clip_cnt go to 0 on the first i_clk edge with i_rst=1. A mid-frame reset discards in-flight pixels; outputs stay 0 until 4 cycles after new valid input.
- Valid definition: valid = i_img_hsync & i_img_vsync, sampled at the input register.
- Latency: exactly 4 clocks from input sample to output, for data, o_img_hsync and o_img_vsync. Strobes go through a 4-deep shift register.
- S1 (input register):
  - capture Y, Cb, Cr and the strobes;
  - form cb = Cb - 128 and cr = Cr - 128 as 9-bit signed values.
- S2 (multiply):
  - 21-bit signed products: P_R_Cr_factor*cr, P_G_Cb_factor*cb, P_G_Cr_factor*cr, P_B_Cb_factor*cb;
  - y1024 = Y<<10;
  - products are forced to 0 when S1 is not valid.
- S3 (sum, 21-bit signed):
  - sR = y1024 + Rcr
  - sG = y1024 - Gcb - Gcr
  - sB = y1024 + Bcb
  - plus the rounding term (see Optional Feature).
  - Ranges are -232320..491625; no overflow at 21 bits.
- S4 (shift and clamp):
  - each sum is arithmetic-shifted right 10;
  - result <0 gives 0, >255 gives 255, otherwise the low 8 bits;
  - RGB outputs are driven only when S3 is valid, else 0 (blanking is black).
- Clip flag: asserted for an output pixel when any of the three channels clamped.
- o_clip_cnt:
  - increments by 1 per valid output pixel with the clip flag set, and saturates at all-ones;
  - clears to 0 on the cycle the output-side vsync rises 0->1;
  - if that clear coincides with a clipped valid pixel, the result is 1;
  - holds its value through vertical blanking so software can read the last frame's count.
- Back-to-back valid pixels are accepted every clock. There is no stall or backpressure.

Optional Feature:
- YCBCR2RGB_ROUND_EN defined: the constant 512 is added in S3 before the shift (round half up).
- Undefined: no constant is added (truncation toward minus infinity).
- Latency and widths are identical in both builds.

Test Plan:
- Reset then Y=128, Cb=128, Cr=128 with hsync=vsync=1 -> 4 cycles later R=G=B=128, o_img_hsync=1; o_clip_cnt unchanged.
- Y=255, Cb=128, Cr=255 -> R=255 (sum 443492 clamped), G=164, B=255; o_clip_cnt increments by 1. Same values in both builds.
- Y=0, Cb=0, Cr=0 -> R=0 (clamped), G=135 in both builds (138624 truncates to 135; 139136 with rounding also gives 135), B=0 (clamped); clip counted.
- Y=76, Cb=85, Cr=255 -> R=254, G=0, B=0 (B sum -221 clamped to 0) -> clip counted. Then hsync=0 mid-line -> RGB outputs 0 exactly 4 cycles later.
- Frame of 10 pixels with 3 clipping pixels -> o_clip_cnt=3 held through vblank; next output vsync rise clears it to 0, or to 1 if the first pixel of the new frame clips on that same cycle.
- Assert i_rst for 1 cycle with 3 pixels in flight -> all outputs 0 on the next edge, no stale pixels emerge. Also drive counter stimulus past 2^22-1 -> o_clip_cnt holds 4194303.
